// File: rtl/chain_code_encoder_if.sv
// Handshake and result bundle between chain_code_encoder, its pixel memory and the
// downstream code consumer.
interface chain_code_encoder_if #(
    parameter int unsigned ADDR_W = 12
);
    logic              start;
    logic              pix_rd;
    logic [ADDR_W-1:0] pix_addr;
    logic              pix_data;
    logic [7:0]        code;
    logic              code_valid;
    logic              code_ready;
    logic [8:0]        perimeter;
    logic [11:0]       area;
    logic [5:0]        startX;
    logic [5:0]        startY;
    logic              busy;
    logic              done;
    logic              error;

    modport master (
        input  start, pix_data, code_ready,
        output pix_rd, pix_addr, code, code_valid,
               perimeter, area, startX, startY, busy, done, error
    );

    modport slave (
        output start, pix_data, code_ready,
        input  pix_rd, pix_addr, code, code_valid,
               perimeter, area, startX, startY, busy, done, error
    );
endinterface

// File: rtl/chain_code_encoder.sv
// Raster-scans a 64x64 binary image, then traces the first object's outer boundary
// and streams 8-direction Freeman codes with perimeter/area/start results.
module chain_code_encoder #(
    parameter int unsigned ADDR_W    = 12,
    parameter int unsigned MAX_PERIM = 511
) (
    input  logic                 clk,
    input  logic                 reset,
    chain_code_encoder_if.master bus
);

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        TRACE_RD,
        TRACE_CHK,
        EMIT,
        DONE
    } state_e;

    typedef struct packed {
        logic       ok;
        logic [5:0] y;
        logic [5:0] x;
    } nb_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    // 7-bit wraparound arithmetic: bit 6 set means the step left the 0..63 range.
    function automatic nb_t neighbour(input logic [5:0] x, input logic [5:0] y,
                                      input logic [2:0] d);
        logic [6:0] nx;
        logic [6:0] ny;
        nb_t        r;
        nx = {1'b0, x};
        ny = {1'b0, y};
        case (d)
            3'd0: nx = nx + 7'd1;
            3'd1: begin nx = nx + 7'd1; ny = ny - 7'd1; end
            3'd2: ny = ny - 7'd1;
            3'd3: begin nx = nx - 7'd1; ny = ny - 7'd1; end
            3'd4: nx = nx - 7'd1;
            3'd5: begin nx = nx - 7'd1; ny = ny + 7'd1; end
            3'd6: ny = ny + 7'd1;
            default: begin nx = nx + 7'd1; ny = ny + 7'd1; end
        endcase
        r.ok = ~nx[6] & ~ny[6];
        r.y  = ny[5:0];
        r.x  = nx[5:0];
        return r;
    endfunction

    function automatic logic [2:0] first_cand(input logic [2:0] d);
        return d[0] ? d + 3'd6 : d + 3'd7;
    endfunction

    state_e            state_q, state_d;
    logic              rd_q, rd_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              chk_q, chk_d;
    logic [ADDR_W-1:0] chk_addr_q, chk_addr_d;
    logic              found_q, found_d;
    logic [11:0]       area_q, area_d;
    logic [5:0]        sx_q, sx_d;
    logic [5:0]        sy_q, sy_d;
    logic              err_q, err_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;
    logic [8:0]        perim_q, perim_d;
    logic [2:0]        code_q, code_d;
    logic              cvalid_q, cvalid_d;
    logic [5:0]        cx_q, cx_d;
    logic [5:0]        cy_q, cy_d;
    logic [2:0]        dir_q, dir_d;
    logic [2:0]        cand_q, cand_d;
    logic [2:0]        tries_q, tries_d;
    logic              miss;
    nb_t               nb_cur;
    nb_t               nb_nxt;

    assign nb_cur = neighbour(cx_q, cy_q, cand_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            rd_q       <= 1'b0;
            addr_q     <= '0;
            chk_q      <= 1'b0;
            chk_addr_q <= '0;
            found_q    <= 1'b0;
            area_q     <= '0;
            sx_q       <= '0;
            sy_q       <= '0;
            err_q      <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            perim_q    <= '0;
            code_q     <= '0;
            cvalid_q   <= 1'b0;
            cx_q       <= '0;
            cy_q       <= '0;
            dir_q      <= '0;
            cand_q     <= '0;
            tries_q    <= '0;
        end else begin
            state_q    <= state_d;
            rd_q       <= rd_d;
            addr_q     <= addr_d;
            chk_q      <= chk_d;
            chk_addr_q <= chk_addr_d;
            found_q    <= found_d;
            area_q     <= area_d;
            sx_q       <= sx_d;
            sy_q       <= sy_d;
            err_q      <= err_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
            perim_q    <= perim_d;
            code_q     <= code_d;
            cvalid_q   <= cvalid_d;
            cx_q       <= cx_d;
            cy_q       <= cy_d;
            dir_q      <= dir_d;
            cand_q     <= cand_d;
            tries_q    <= tries_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        rd_d       = 1'b0;
        addr_d     = addr_q;
        chk_d      = 1'b0;
        chk_addr_d = chk_addr_q;
        found_d    = found_q;
        area_d     = area_q;
        sx_d       = sx_q;
        sy_d       = sy_q;
        err_d      = err_q;
        done_d     = done_q;
        busy_d     = busy_q;
        perim_d    = perim_q;
        code_d     = code_q;
        cvalid_d   = cvalid_q;
        cx_d       = cx_q;
        cy_d       = cy_q;
        dir_d      = dir_q;
        cand_d     = cand_q;
        tries_d    = tries_q;
        miss       = 1'b0;
        nb_nxt     = '0;

        unique case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    perim_d = '0;
                    area_d  = '0;
                    err_d   = 1'b0;
                    done_d  = 1'b0;
                    busy_d  = 1'b1;
                    found_d = 1'b0;
                    rd_d    = 1'b1;
                    addr_d  = '0;
                    state_d = SCAN;
                end
            end

            SCAN: begin
                if (rd_q) begin
                    chk_d      = 1'b1;
                    chk_addr_d = addr_q;
                    if (addr_q != LAST_ADDR) begin
                        rd_d   = 1'b1;
                        addr_d = addr_q + ADDR_W'(1);
                    end
                end
                if (chk_q && bus.pix_data) begin
                    if (area_q == '1) begin
                        err_d = 1'b1;
                    end else begin
                        area_d = area_q + 12'd1;
                    end
                    if (!found_q) begin
                        found_d = 1'b1;
                        sx_d    = chk_addr_q[5:0];
                        sy_d    = chk_addr_q[11:6];
                    end
                end
                if (chk_q && chk_addr_q == LAST_ADDR) begin
                    if (!found_d) begin
                        err_d   = 1'b1;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        cx_d    = sx_d;
                        cy_d    = sy_d;
                        dir_d   = 3'd7;
                        cand_d  = first_cand(3'd7);
                        tries_d = '0;
                        state_d = TRACE_RD;
                    end
                end
            end

            TRACE_RD: begin
                if (nb_cur.ok) begin
                    state_d = TRACE_CHK;
                end else begin
                    miss = 1'b1;
                end
            end

            TRACE_CHK: begin
                if (bus.pix_data) begin
                    if (perim_q == 9'(MAX_PERIM)) begin
                        err_d   = 1'b1;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        dir_d    = cand_q;
                        cx_d     = nb_cur.x;
                        cy_d     = nb_cur.y;
                        code_d   = cand_q;
                        cvalid_d = 1'b1;
                        state_d  = EMIT;
                    end
                end else begin
                    miss = 1'b1;
                end
            end

            EMIT: begin
                if (bus.code_ready) begin
                    perim_d  = perim_q + 9'd1;
                    cvalid_d = 1'b0;
                    if (cx_q == sx_q && cy_q == sy_q) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        cand_d  = first_cand(dir_q);
                        tries_d = '0;
                        state_d = TRACE_RD;
                    end
                end
            end

            default: state_d = IDLE;
        endcase

        // Off-image and background candidates share one advance path.
        if (miss) begin
            if (tries_q == 3'd7) begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = DONE;
            end else begin
                cand_d  = cand_q + 3'd1;
                tries_d = tries_q + 3'd1;
                state_d = TRACE_RD;
            end
        end

        // pix_rd/pix_addr are registered, so the read is set up for the state being entered.
        if (state_d == TRACE_RD) begin
            nb_nxt = neighbour(cx_d, cy_d, cand_d);
            rd_d   = nb_nxt.ok;
            addr_d = ADDR_W'({nb_nxt.y, nb_nxt.x});
        end
    end

    assign bus.pix_rd     = rd_q;
    assign bus.pix_addr   = addr_q;
    assign bus.code       = {5'b00000, code_q};
    assign bus.code_valid = cvalid_q;
    assign bus.perimeter  = perim_q;
    assign bus.area       = area_q;
    assign bus.startX     = sx_q;
    assign bus.startY     = sy_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.error      = err_q;

endmodule

// File: tb/tb_chain_code_encoder.sv
// Bench for chain_code_encoder: table of shape vectors, corner sequences and random
// images checked against a boundary-following reference model.
module tb_chain_code_encoder;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    chain_code_encoder_if #(.ADDR_W(12)) bus ();

    chain_code_encoder #(
        .ADDR_W   (12),
        .MAX_PERIM(511)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    logic [4095:0] img;
    always @(posedge clk) bus.pix_data <= bus.pix_rd ? img[bus.pix_addr] : 1'b0;

    typedef struct {
        int x0, y0, w, h;
        int rmode;
        int perim, area, sx, sy;
        int err;
    } vec_t;

    vec_t tbl[9];
    int   n_vec = 0;
    int   n_bad = 0;
    int   got_codes[$];
    int   exp_codes[$];
    int   rd_cnt, stall_err, timed_out;
    int   exp_reads, exp_area, exp_perim, exp_sx, exp_sy, exp_err;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic draw_rect(input int x0, input int y0, input int w, input int h);
        for (int y = y0; y < y0 + h && y < 64; y++)
            for (int x = x0; x < x0 + w && x < 64; x++)
                img[y*64 + x] = 1'b1;
    endtask

    // Reference: raster search, then neighbour-following from the start pixel.
    task automatic model();
        int dx[8] = '{1, 1, 0, -1, -1, -1, 0, 1};
        int dy[8] = '{0, -1, -1, -1, 0, 1, 1, 1};
        int cx, cy, d, c, nx, ny;
        bit found, hit;
        exp_codes.delete();
        exp_area = 0; exp_err = 0; exp_perim = 0; exp_reads = 4096;
        exp_sx = 0; exp_sy = 0; found = 0; nx = 0; ny = 0;
        for (int a = 0; a < 4096; a++) begin
            if (img[a]) begin
                if (exp_area == 4095) exp_err = 1;
                else exp_area++;
                if (!found) begin found = 1; exp_sx = a % 64; exp_sy = a / 64; end
            end
        end
        if (!found) begin exp_err = 1; return; end
        cx = exp_sx; cy = exp_sy; d = 7;
        forever begin
            c = (d % 2 == 0) ? (d + 7) % 8 : (d + 6) % 8;
            hit = 0;
            for (int k = 0; k < 8; k++) begin
                nx = cx + dx[c]; ny = cy + dy[c];
                if (nx >= 0 && nx < 64 && ny >= 0 && ny < 64) begin
                    exp_reads++;
                    if (img[ny*64 + nx]) begin hit = 1; break; end
                end
                c = (c + 1) % 8;
            end
            if (!hit) return;
            if (exp_perim == 511) begin exp_err = 1; return; end
            exp_codes.push_back(c);
            exp_perim++;
            d = c; cx = nx; cy = ny;
            if (cx == exp_sx && cy == exp_sy) return;
        end
    endtask

    // rmode: 0 ready tied high, 1 five-cycle stall on first code, 2 random ready.
    task automatic run_job(input int rmode, input int abort_at, input bit poke_start);
        int cyc, stalls;
        bit prev_stall;
        logic [7:0] prev_code;
        got_codes.delete();
        rd_cnt = 0; stall_err = 0; timed_out = 0;
        cyc = 0; stalls = 0; prev_stall = 0; prev_code = '0;
        @(negedge clk); bus.start = 1'b1;
        @(negedge clk); bus.start = 1'b0;
        while (!bus.done) begin
            if (bus.pix_rd) rd_cnt++;
            case (rmode)
                0: bus.code_ready = 1'b1;
                1: begin
                    if (bus.code_valid && got_codes.size() == 0 && stalls < 5) begin
                        bus.code_ready = 1'b0;
                        stalls++;
                    end else begin
                        bus.code_ready = 1'b1;
                    end
                end
                default: bus.code_ready = ($urandom_range(0, 3) != 0);
            endcase
            if (prev_stall && (!bus.code_valid || bus.code !== prev_code)) stall_err++;
            prev_stall = bus.code_valid && !bus.code_ready;
            prev_code  = bus.code;
            if (bus.code_valid && bus.code_ready) got_codes.push_back(int'(bus.code));
            bus.start = poke_start && (cyc == 50 || (bus.code_valid && got_codes.size() == 1));
            if (abort_at > 0 && got_codes.size() == abort_at) return;
            cyc++;
            if (cyc > 20000) begin timed_out = 1; break; end
            @(negedge clk);
        end
        bus.start = 1'b0;
    endtask

    task automatic check_job(input string tag, input int perim, input int area,
                             input int sx, input int sy, input int err);
        chk({tag, ".timeout"}, timed_out, 0);
        chk({tag, ".done"}, bus.done, 1);
        chk({tag, ".busy"}, bus.busy, 0);
        chk({tag, ".perimeter"}, bus.perimeter, perim);
        chk({tag, ".area"}, bus.area, area);
        chk({tag, ".error"}, bus.error, err);
        if (area > 0) begin
            chk({tag, ".startX"}, bus.startX, sx);
            chk({tag, ".startY"}, bus.startY, sy);
        end
        chk({tag, ".ncodes"}, got_codes.size(), exp_codes.size());
        for (int i = 0; i < got_codes.size() && i < exp_codes.size(); i++)
            chk($sformatf("%s.code%0d", tag, i), got_codes[i], exp_codes[i]);
        chk({tag, ".reads"}, rd_cnt, exp_reads);
        chk({tag, ".stall_hold"}, stall_err, 0);
    endtask

    initial begin
        tbl[0] = '{10, 20, 3, 2, 0, 6, 6, 10, 20, 0};
        tbl[1] = '{10, 20, 3, 2, 1, 6, 6, 10, 20, 0};
        tbl[2] = '{0, 0, 1, 1, 0, 0, 1, 0, 0, 0};
        tbl[3] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
        tbl[4] = '{0, 0, 64, 64, 0, 252, 4095, 0, 0, 1};
        tbl[5] = '{63, 63, 1, 1, 0, 0, 1, 63, 63, 0};
        tbl[6] = '{0, 62, 64, 2, 2, 128, 128, 0, 62, 0};
        tbl[7] = '{5, 5, 4, 1, 2, 6, 4, 5, 5, 0};
        tbl[8] = '{2, 2, 1, 3, 0, 4, 3, 2, 2, 0};

        bus.start = 1'b0;
        bus.code_ready = 1'b0;
        img = '0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset.outputs", {bus.pix_rd, bus.pix_addr, bus.code, bus.code_valid,
            bus.perimeter, bus.area, bus.startX, bus.startY, bus.busy, bus.done, bus.error}, '0);
        reset = 1'b0;

        for (int v = 0; v < 9; v++) begin
            img = '0;
            draw_rect(tbl[v].x0, tbl[v].y0, tbl[v].w, tbl[v].h);
            model();
            run_job(tbl[v].rmode, 0, 1'b0);
            check_job($sformatf("vec%0d", v), tbl[v].perim, tbl[v].area,
                      tbl[v].sx, tbl[v].sy, tbl[v].err);
        end

        // Abort after the second code, then rerun with start pulsed while busy.
        img = '0;
        draw_rect(10, 20, 3, 2);
        model();
        run_job(0, 2, 1'b0);
        chk("abort.ncodes", got_codes.size(), 2);
        reset = 1'b1;
        @(negedge clk);
        chk("abort.outputs", {bus.pix_rd, bus.pix_addr, bus.code, bus.code_valid,
            bus.perimeter, bus.area, bus.startX, bus.startY, bus.busy, bus.done, bus.error}, '0);
        reset = 1'b0;
        run_job(0, 0, 1'b1);
        check_job("rerun", 6, 6, 10, 20, 0);

        for (int r = 0; r < 4; r++) begin
            img = '0;
            for (int k = 0; k < 2; k++)
                draw_rect($urandom_range(0, 63), $urandom_range(0, 63),
                          $urandom_range(1, 10), $urandom_range(1, 10));
            for (int k = 0; k < 8; k++) img[$urandom_range(0, 4095)] = 1'b1;
            model();
            run_job(2, 0, 1'b0);
            check_job($sformatf("rand%0d", r), exp_perim, exp_area, exp_sx, exp_sy, exp_err);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
